// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index into the request vector: bit 0 = fetch, bit 1 = data.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the one not
// granted last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic       gnt_valid,
  output owner_t     gnt_id
);

  // Winner select
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWN_IF;
    if (req == 2'b11)
      gnt_id = (last == OWN_IF) ? OWN_DM : OWN_IF;
    else if (req[OWN_DM])
      gnt_id = OWN_DM;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port RAM between instruction fetch
// and the load/store unit. One grant = IDLE -> ACCESS -> DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_saida,
  output logic              busy
);

  state_t state, state_nxt;
  owner_t owner, last_grant;
  owner_t gnt_id;
  logic   gnt_valid;
  logic   acc_we;   // latched dm_we of the current data access
  logic   acc_oor;  // current data access is out of range
  logic   dm_in_range;

  assign dm_in_range = (32'(dm_addr) < DEPTH);
  assign busy        = (state == ACCESS) || (state == DONE);

  rr_pick2 u_pick (
    .req       ({dm_req, if_req}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: requests are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latching, RAM drive and response capture; reset kills a pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= OWN_IF;
      last_grant   <= OWN_DM;
      acc_we       <= 1'b0;
      acc_oor      <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      mem_write    <= 1'b0;
      if_ack       <= 1'b0;
      if_rdata     <= '0;
      dm_ack       <= 1'b0;
      dm_rdata     <= '0;
      dm_err       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      dm_err <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          owner      <= gnt_id;
          last_grant <= gnt_id;
          if (gnt_id == OWN_DM) begin
            mem_endereco <= dm_addr;
            mem_dado     <= dm_wdata;
            mem_write    <= dm_we & dm_in_range;
            acc_we       <= dm_we;
            acc_oor      <= ~dm_in_range;
          end else begin
            mem_endereco <= if_addr;
            mem_write    <= 1'b0;
            acc_we       <= 1'b0;
            acc_oor      <= 1'b0;
          end
        end
        ACCESS: begin
          mem_write <= 1'b0;
          if (owner == OWN_IF) begin
            if_rdata <= mem_saida;
            if_ack   <= 1'b1;
          end else begin
            dm_rdata <= (acc_we || acc_oor) ? '0 : mem_saida;
            dm_err   <= acc_oor;
            dm_ack   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 128-word RAM
// (write on rising edge, read on falling edge).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [31:0] mem_dado, mem_saida;
  logic [9:0]  mem_endereco;
  logic        mem_write, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram [128];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_dado(mem_dado), .mem_endereco(mem_endereco), .mem_write(mem_write),
    .mem_saida(mem_saida), .busy(busy)
  );

  // RAM model: only the low 7 address bits are decoded
  always @(posedge clk) if (mem_write) ram[mem_endereco[6:0]] <= mem_dado;
  always @(negedge clk) mem_saida <= ram[mem_endereco[6:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One data access from IDLE; returns latency in edges and write-cycles seen
  task automatic dm_access(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err,
                           output int lat, output int wr_seen);
    dm_we = we; dm_addr = addr; dm_wdata = wd; dm_req = 1'b1;
    lat = 0; wr_seen = 0;
    while (!dm_ack && lat < 20) begin
      step();
      lat++;
      if (mem_write) wr_seen++;
    end
    rd  = dm_rdata;
    err = dm_err;
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    if_addr = '0; dm_we = 1'b1; dm_addr = 10'd1; dm_wdata = 32'hFFFF_FFFF;
    step(); step();
    n_cmp++;
    if ({busy, if_ack, dm_ack, dm_err, mem_write} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 00000", {busy, if_ack, dm_ack, dm_err, mem_write});
    end
    n_cmp++;
    if ({if_rdata, dm_rdata, mem_dado, mem_endereco} !== '0) begin
      n_bad++; $display("FAIL reset_data got %h/%h/%h/%h want 0", if_rdata, dm_rdata, mem_dado, mem_endereco);
    end
    if_req = 1'b0; dm_req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_conflict();
    int t, t_if, t_dm;
    int wr_in_fetch;
    if_addr = 10'd3; dm_we = 1'b0; dm_addr = 10'd4; dm_wdata = '0;
    if_req = 1'b1; dm_req = 1'b1;
    t = 0; t_if = -1; t_dm = -1; wr_in_fetch = 0;
    while (t_dm < 0 && t < 20) begin
      step(); t++;
      if (t_if < 0 && mem_write) wr_in_fetch++;
      if (if_ack) begin t_if = t; if_req = 1'b0; end
      if (dm_ack) begin t_dm = t; dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
    n_cmp++;
    if (t_if !== 2 || t_dm !== 5) begin
      n_bad++; $display("FAIL conflict_order got if@%0d dm@%0d want if@2 dm@5", t_if, t_dm);
    end
    n_cmp++;
    if (wr_in_fetch !== 0) begin
      n_bad++; $display("FAIL conflict_nowrite got %0d write cycles want 0", wr_in_fetch);
    end
    n_cmp++;
    if (if_rdata !== 32'hA000_0003 || dm_rdata !== 32'hA000_0004) begin
      n_bad++; $display("FAIL conflict_data got %h/%h want a0000003/a0000004", if_rdata, dm_rdata);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; int lat, wr;
    dm_access(1'b1, 10'd5, 32'hDEAD_BEEF, rd, err, lat, wr);
    n_cmp++;
    if (lat !== 2 || wr !== 1 || err !== 1'b0 || rd !== 32'h0) begin
      n_bad++; $display("FAIL store got lat=%0d wr=%0d err=%b rd=%h want 2/1/0/0", lat, wr, err, rd);
    end
    dm_access(1'b0, 10'd5, 32'h0, rd, err, lat, wr);
    n_cmp++;
    if (lat !== 2 || wr !== 0 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL load got lat=%0d wr=%0d err=%b rd=%h want 2/0/0/deadbeef", lat, wr, err, rd);
    end
  endtask

  task automatic test_contention();
    int t, n;
    owner_seq_t: begin end
    n = 0; t = 0;
    begin
      logic [3:0] who;  // 0 = IF, 1 = DM, per ack in order
      int tm [4];
      who = '1;
      if_addr = 10'd10; dm_we = 1'b0; dm_addr = 10'd11;
      if_req = 1'b1; dm_req = 1'b1;
      while (n < 4 && t < 40) begin
        step(); t++;
        if (if_ack) begin who[n] = 1'b0; tm[n] = t; n++; if_req = 1'b0; end
        else if (dm_ack) begin who[n] = 1'b1; tm[n] = t; n++; dm_req = 1'b0; end
        else begin if_req = 1'b1; dm_req = 1'b1; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      step(); step();
      n_cmp++;
      if (n !== 4 || who !== 4'b1010) begin
        n_bad++; $display("FAIL contention_order got n=%0d seq=%b want 4 seq=1010", n, who);
      end
      n_cmp++;
      if (n == 4 && ((tm[2] - tm[0]) > 6 || (tm[3] - tm[1]) > 6)) begin
        n_bad++; $display("FAIL contention_wait got gaps %0d/%0d want <=6", tm[2] - tm[0], tm[3] - tm[1]);
      end
      n_cmp++;
      if (if_rdata !== 32'hA000_000A || dm_rdata !== 32'hA000_000B) begin
        n_bad++; $display("FAIL contention_data got %h/%h want a000000a/a000000b", if_rdata, dm_rdata);
      end
    end
  endtask

  task automatic test_oor();
    logic [31:0] rd; logic err; int lat, wr;
    dm_access(1'b1, 10'd200, 32'h1234_5678, rd, err, lat, wr);
    n_cmp++;
    if (lat !== 2 || wr !== 0 || err !== 1'b1 || rd !== 32'h0) begin
      n_bad++; $display("FAIL oor_store got lat=%0d wr=%0d err=%b rd=%h want 2/0/1/0", lat, wr, err, rd);
    end
    dm_access(1'b0, 10'd72, 32'h0, rd, err, lat, wr);
    n_cmp++;
    if (rd !== 32'hA000_0048 || err !== 1'b0) begin
      n_bad++; $display("FAIL oor_alias got rd=%h err=%b want a0000048/0", rd, err);
    end
  endtask

  task automatic test_abort();
    dm_we = 1'b1; dm_addr = 10'd9; dm_wdata = 32'h55AA_55AA; dm_req = 1'b1;
    step();
    n_cmp++;
    if (mem_write !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL abort_arm got write=%b busy=%b want 1/1", mem_write, busy);
    end
    #1 rst_n = 1'b0; dm_req = 1'b0;
    #1;
    n_cmp++;
    if (mem_write !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_drop got write=%b busy=%b want 0/0", mem_write, busy);
    end
    step(); step();
    n_cmp++;
    if (ram[9] !== 32'hA000_0009 || dm_ack !== 1'b0) begin
      n_bad++; $display("FAIL abort_mem got ram9=%h ack=%b want a0000009/0", ram[9], dm_ack);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0 || dm_ack !== 1'b0 || if_ack !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle got busy=%b dm_ack=%b if_ack=%b want 0", busy, dm_ack, if_ack);
    end
  endtask

  task automatic test_program_fetch();
    int t, n;
    int tm [3];
    logic [31:0] rd [3];
    t = 0; n = 0;
    if_addr = 10'd0; if_req = 1'b1;
    while (n < 3 && t < 30) begin
      step(); t++;
      if (if_ack) begin
        tm[n] = t; rd[n] = if_rdata; n++;
        if_addr = 10'(n);
        if (n == 3) if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    step();
    n_cmp++;
    if (n !== 3) begin
      n_bad++; $display("FAIL fetch_count got %0d acks want 3", n);
    end else begin
      n_cmp++;
      if (rd[0] !== 32'h0400_0001 || rd[1] !== 32'hA000_0001 || rd[2] !== 32'hA000_0002) begin
        n_bad++; $display("FAIL fetch_data got %h %h %h want 04000001 a0000001 a0000002", rd[0], rd[1], rd[2]);
      end
      n_cmp++;
      if (tm[0] !== 2 || (tm[1] - tm[0]) !== 3 || (tm[2] - tm[1]) !== 3) begin
        n_bad++; $display("FAIL fetch_spacing got first=%0d gaps %0d/%0d want 2 3/3", tm[0], tm[1] - tm[0], tm[2] - tm[1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'hA000_0000 | 32'(i);
    ram[0] = 32'h0400_0001;
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    if_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_conflict();
    test_store_load();
    test_contention();
    test_oor();
    test_abort();
    test_program_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
